// File: rtl/quad_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : quad_decoder
//  Description : Rotary-encoder A/B quadrature decoder. Produces synchronised,
//                debounced, one-cycle cw/ccw detent pulses and an err pulse
//                on illegal two-bit jumps.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_decoder #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  output logic cw,
  output logic ccw,
  output logic err
);

  localparam int                  c_CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]  c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_INIT_DONE = c_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
  localparam logic signed [2:0]   c_ACC_MAX   = 3'sd3;
  localparam logic signed [2:0]   c_ACC_MIN   = -3'sd3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_a_meta, r_b_meta;
  logic                r_a_s, r_b_s;
  logic [1:0]          r_ab_last;
  logic [c_CNT_W-1:0]  r_init_cnt;
  logic [c_CNT_W-1:0]  r_cnt_a, r_cnt_b;
  logic [1:0]          r_f;       // {a_f, b_f}
  logic [1:0]          r_f_prev;
  logic signed [2:0]   r_acc;
  logic                r_cw, r_ccw, r_err;

  logic [1:0]          w_ab_s;
  logic                w_fwd, w_rev, w_ill;

  assign w_ab_s = {r_a_s, r_b_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_meta <= 1'b0;
      r_b_meta <= 1'b0;
      r_a_s    <= 1'b0;
      r_b_s    <= 1'b0;
    end else begin
      r_a_meta <= enc_a;
      r_b_meta <= enc_b;
      r_a_s    <= r_a_meta;
      r_b_s    <= r_b_meta;
    end
  end

  // Gray-code step classification of the filtered state against last cycle.
  always_comb begin
    w_fwd = 1'b0;
    w_rev = 1'b0;
    case ({r_f_prev, r_f})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_rev = 1'b1;
      default: ;
    endcase
  end

  assign w_ill = ((r_f_prev ^ r_f) == 2'b11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_ab_last  <= 2'b00;
      r_init_cnt <= '0;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_f        <= 2'b00;
      r_f_prev   <= 2'b00;
      r_acc      <= 3'sd0;
      r_cw       <= 1'b0;
      r_ccw      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cw  <= 1'b0;
      r_ccw <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_ab_last <= w_ab_s;
          if (w_ab_s != r_ab_last) begin
            r_init_cnt <= '0;
          end else if (r_init_cnt == c_INIT_DONE) begin
            // Seed both filtered copies so entering RUN decodes no step.
            r_state    <= ST_RUN;
            r_f        <= w_ab_s;
            r_f_prev   <= w_ab_s;
            r_acc      <= 3'sd0;
            r_init_cnt <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + c_CNT_ONE;
          end
        end

        ST_RUN: begin
          r_f_prev <= r_f;
          if (w_ill) begin
            r_err <= 1'b1;
            r_acc <= 3'sd0;
          end else if (w_fwd) begin
            if (r_acc == c_ACC_MAX) begin
              r_cw  <= 1'b1;
              r_acc <= 3'sd0;
            end else begin
              r_acc <= r_acc + 3'sd1;
            end
          end else if (w_rev) begin
            if (r_acc == c_ACC_MIN) begin
              r_ccw <= 1'b1;
              r_acc <= 3'sd0;
            end else begin
              r_acc <= r_acc - 3'sd1;
            end
          end

          if (r_a_s == r_f[1]) begin
            r_cnt_a <= '0;
          end else if (r_cnt_a == c_DB_LAST) begin
            r_f[1]  <= r_a_s;
            r_cnt_a <= '0;
          end else begin
            r_cnt_a <= r_cnt_a + c_CNT_ONE;
          end

          if (r_b_s == r_f[0]) begin
            r_cnt_b <= '0;
          end else if (r_cnt_b == c_DB_LAST) begin
            r_f[0]  <= r_b_s;
            r_cnt_b <= '0;
          end else begin
            r_cnt_b <= r_cnt_b + c_CNT_ONE;
          end
        end

        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign cw  = r_cw;
  assign ccw = r_ccw;
  assign err = r_err;

endmodule
`default_nettype wire
